reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
Write-side controller for the 32x32 register bank: it sequences every register write (ALU results and load returns) onto the bank's single write port (writeReg/writeData/canWrite). Retirement is in order. A small pending-write queue lets multicycle loads complete out of step with issue, while younger ALU results wait behind them. A destination scoreboard flags read-after-write hazards on the rs/rt read addresses so the datapath can stall.

Parameters:
DEPTH, 4, pending-write queue entries (power of two, 2..16)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
issue_valid  input  1  instruction with register destination issued this cycle
issue_ready  output  1  queue can accept an issue (registered, = !full)
issue_dest  input  5  destination register (already muxed rt/rd/$31)
issue_is_load  input  1  1 = data arrives later on load_*, 0 = data on issue_data
issue_data  input  32  ALU/link result, sampled when issue_is_load=0
load_valid  input  1  load data return, in program order
load_data  input  32  returned load word
rs_addr  input  5  read address 1 for hazard check
rt_addr  input  5  read address 2 for hazard check
rs_hazard  output  1  pending write to rs_addr (combinational)
rt_hazard  output  1  pending write to rt_addr (combinational)
writeReg  output  5  register bank write address (registered)
writeData  output  32  register bank write data (registered)
canWrite  output  1  register bank write enable (registered, 1-cycle pulse per write)
load_err  output  1  sticky: load_valid with no outstanding load entry
empty  output  1  no pending entries

Behaviour:
- Entry fields: dest[4:0], data[31:0], ready. Queue pointers: head, tail, load_ptr (oldest unfilled load entry), and a count register.
- Reset (reset=0 at posedge): count/head/tail/load_ptr=0, all entries invalid, writeReg=0, writeData=0, canWrite=0, load_err=0. issue_ready=1 and empty=1 from the first cycle after reset. Reset mid-operation discards all pending writes; no canWrite follows.
- Issue accept: issue_valid && issue_ready. The entry is written at tail; ready = !issue_is_load; data = issue_data when not a load.
- Load return: load_valid fills the entry at load_ptr, sets ready=1, and advances load_ptr to the next load entry.
  - If no unfilled load entry exists, the data is dropped and load_err is set to 1 (held until reset).
  - A load_valid in the same cycle as the accept of a load issue does not fill that new entry.
- Retire: if the head entry is valid and ready, it is popped and a write is registered for the next cycle: canWrite=1, writeReg=dest, writeData=data. Otherwise canWrite=0 next cycle. At most one retire per cycle.
- Register 0: dest=0 entries are queued and retired normally, but canWrite stays 0 for them, and they never raise a hazard.
- Latency:
  - ALU issue at cycle N onto an empty queue -> canWrite at N+1.
  - Load return at cycle M for the head entry -> canWrite at M+1.
  - A ready entry blocked behind an unready head retires one cycle per entry after the head retires.
- Full: issue_ready = (count < DEPTH), based on registered state. A same-cycle retire does not open a slot until the next cycle. Issue when issue_ready=0 is ignored and the entry is not written.
- Simultaneous accept + retire: count unchanged. Pointers wrap modulo DEPTH.
- Hazards: rs_hazard = (rs_addr != 0) && any valid entry has dest == rs_addr; rt_hazard likewise for rt_addr.
  - Entries still in the queue count, including the head being retired this cycle.
  - The already-registered canWrite output does not count; the bank write takes effect at that edge.
- empty = (count == 0).

Test Plan:
- Reset: hold reset=0 for 2 cycles with issue_valid=1 -> canWrite=0, writeReg=0, writeData=0, empty=1, issue_ready=1, load_err=0.
- Single ALU write: issue dest=5, data=0xDEADBEEF at cycle N -> canWrite=1, writeReg=5, writeData=0xDEADBEEF at N+1 only; rs_addr=5 gives rs_hazard=1 during N+1 issue-to-retire window, then 0.
- Load then ALU ordering: issue load dest=8, then ALU dest=9 data=7; load_valid data=0x100 three cycles later -> writes (8,0x100) then (9,7) on consecutive cycles; rt_addr=9 gives rt_hazard=1 until the retire.
- Full queue: 4 loads issued without returns -> issue_ready=0 and a 5th issue is ignored. Return 4 words 1,2,3,4 -> 4 consecutive writes in issue order; issue_ready=1 after the first retire.
- Register 0 and stray load: issue ALU dest=0 -> no canWrite, rs_addr=0 gives rs_hazard=0. Then load_valid on an empty queue -> load_err=1 and stays set until reset.
- Reset mid-operation: 3 pending entries, reset=0 for 1 cycle -> empty=1 and no later canWrite even when load_valid arrives; load_err=1 for that stray return.

Source files
------------

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit
// Purpose  : In-order write sequencer for the 32x32 register bank. Holds a
//            small ring of pending writes (ALU results and outstanding loads),
//            retires ready head entries onto the single bank write port and
//            flags read-after-write hazards on the rs/rt read addresses.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_dest,
  input  logic        issue_is_load,
  input  logic [31:0] issue_data,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_hazard,
  output logic        rt_hazard,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        canWrite,
  output logic        load_err,
  output logic        empty
);

  // Entry storage: valid/ready flags are reset, payload is not.
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] rdy_q;
  logic [4:0]       dest_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] load_ptr_q, load_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [4:0]       write_reg_q;
  logic [31:0]      write_data_q;
  logic             can_write_q;
  logic             load_err_q;

  logic             accept;
  logic             retire;
  logic             fill;
  logic [DEPTH-1:0] unfilled;
  logic [DEPTH-1:0] unfilled_next;
  logic             scan_found;
  logic [PTR_W-1:0] scan_idx;

  // Capacity is judged on registered state only, so a same-cycle retire
  // does not free a slot until the following cycle.
  assign issue_ready = (count_q < (PTR_W+1)'(DEPTH));
  assign empty       = (count_q == '0);

  assign accept   = issue_valid && issue_ready;
  assign unfilled = vld_q & ~rdy_q;
  // Loads return in program order, so the oldest unfilled entry is the target.
  assign fill     = load_valid && (|unfilled);
  assign retire   = vld_q[head_q] && rdy_q[head_q];

  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign canWrite  = can_write_q;
  assign load_err  = load_err_q;

  // Pointer/count next state and the oldest-unfilled-load search.
  always_comb begin
    head_d  = retire ? head_q + 1'b1 : head_q;
    tail_d  = accept ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PTR_W+1)'(accept) - (PTR_W+1)'(retire);

    // Unfilled set as it will be after this edge; a load accepted this cycle
    // is added only after the fill, so a same-cycle return cannot hit it.
    unfilled_next = unfilled;
    if (fill)
      unfilled_next[load_ptr_q] = 1'b0;
    if (accept && issue_is_load)
      unfilled_next[tail_q] = 1'b1;

    // Scan in age order starting at the head; retiring entries are ready and
    // so never appear in the unfilled set.
    load_ptr_d = load_ptr_q;
    scan_found = 1'b0;
    scan_idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (!scan_found && unfilled_next[scan_idx]) begin
        load_ptr_d = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  // Hazard detection over every queued entry, register 0 excluded.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (dest_q[i] == rs_addr)) rs_hazard = 1'b1;
      if (vld_q[i] && (dest_q[i] == rt_addr)) rt_hazard = 1'b1;
    end
    if (rs_addr == 5'd0) rs_hazard = 1'b0;
    if (rt_addr == 5'd0) rt_hazard = 1'b0;
  end

  // Control state: pointers, entry flags, bank write port and error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q        <= '0;
      rdy_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      load_ptr_q   <= '0;
      count_q      <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      can_write_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      load_ptr_q <= load_ptr_d;
      count_q    <= count_d;

      if (retire)
        vld_q[head_q] <= 1'b0;
      if (accept) begin
        vld_q[tail_q] <= 1'b1;
        rdy_q[tail_q] <= !issue_is_load;
      end
      if (fill)
        rdy_q[load_ptr_q] <= 1'b1;

      // Writes to register 0 are retired silently.
      can_write_q <= retire && (dest_q[head_q] != 5'd0);
      if (retire && (dest_q[head_q] != 5'd0)) begin
        write_reg_q  <= dest_q[head_q];
        write_data_q <= data_q[head_q];
      end

      if (load_valid && !(|unfilled))
        load_err_q <= 1'b1;
    end
  end

  // Entry payload: destination and data captured on issue, data on load fill.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      dest_q[tail_q] <= issue_dest;
      if (!issue_is_load)
        data_q[tail_q] <= issue_data;
    end
    if (reset && fill)
      data_q[load_ptr_q] <= load_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_unit
// Purpose  : Self-checking bench for reg_writeback_unit. A queue-level model
//            of the pending writes predicts bank writes into a scoreboard and
//            the status/hazard outputs each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_unit;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic        rdy;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_dest;
  logic        issue_is_load;
  logic [31:0] issue_data;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_hazard;
  logic        rt_hazard;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        canWrite;
  logic        load_err;
  logic        empty;

  reg_writeback_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load), .issue_data(issue_data),
    .load_valid(load_valid), .load_data(load_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_hazard(rs_hazard), .rt_hazard(rt_hazard),
    .writeReg(writeReg), .writeData(writeData), .canWrite(canWrite),
    .load_err(load_err), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: pending writes in program order, expected bank writes.
  ent_t mq[$];
  ent_t expq[$];
  logic m_err;
  logic m_rst;
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic int outstanding_loads();
    int n = 0;
    foreach (mq[i]) if (!mq[i].rdy) n++;
    return n;
  endfunction

  function automatic logic model_hazard(input logic [4:0] a);
    logic h = 1'b0;
    foreach (mq[i]) if (mq[i].dest == a) h = 1'b1;
    return h && (a != 5'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one clock edge of the behavioural rules to the model.
  task automatic model_edge();
    int   old_size;
    logic ret;
    logic found;
    ent_t e;
    if (!reset) begin
      mq.delete();
      m_err = 1'b0;
      m_rst = 1'b1;
    end else begin
      m_rst    = 1'b0;
      old_size = mq.size();
      ret      = (old_size > 0) && mq[0].rdy;
      if (load_valid) begin
        found = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
          if (!found && !mq[i].rdy) begin
            e = mq[i];
            e.data = load_data;
            e.rdy  = 1'b1;
            mq[i]  = e;
            found  = 1'b1;
          end
        end
        if (!found) m_err = 1'b1;
      end
      if (ret) begin
        e = mq.pop_front();
        if (e.dest != 5'd0) expq.push_back(e);
      end
      if (issue_valid && (old_size < DEPTH)) begin
        e.dest = issue_dest;
        e.data = issue_is_load ? 32'd0 : issue_data;
        e.rdy  = !issue_is_load;
        mq.push_back(e);
      end
    end
  endtask

  // Model update on the active edge, comparisons mid-cycle.
  initial begin
    ent_t w;
    m_err = 1'b0;
    m_rst = 1'b0;
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
      chk("issue_ready", 32'(issue_ready), 32'(mq.size() < DEPTH));
      chk("empty",       32'(empty),       32'(mq.size() == 0));
      chk("load_err",    32'(load_err),    32'(m_err));
      chk("rs_hazard",   32'(rs_hazard),   32'(model_hazard(rs_addr)));
      chk("rt_hazard",   32'(rt_hazard),   32'(model_hazard(rt_addr)));
      chk("canWrite",    32'(canWrite),    32'(expq.size() > 0));
      if (m_rst) begin
        chk("writeReg_rst",  32'(writeReg), 32'd0);
        chk("writeData_rst", writeData,     32'd0);
      end
      if (expq.size() > 0) begin
        w = expq.pop_front();
        if (canWrite) begin
          chk("writeReg",  32'(writeReg), 32'(w.dest));
          chk("writeData", writeData,     w.data);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic iv, input logic [4:0] dst,
                      input logic ld, input logic [31:0] dat,
                      input logic lv, input logic [31:0] ldat,
                      input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk);
    reset = rst; issue_valid = iv; issue_dest = dst; issue_is_load = ld;
    issue_data = dat; load_valid = lv; load_data = ldat; rs_addr = rs; rt_addr = rt;
  endtask

  task automatic idle(input int n, input logic [4:0] rs, input logic [4:0] rt);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, rs, rt);
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b1; issue_dest = 5'd3; issue_is_load = 1'b0;
    issue_data = 32'h1234; load_valid = 1'b0; load_data = '0; rs_addr = '0; rt_addr = '0;

    // Reset held two edges with an issue pending.
    step(0, 1, 5'd3, 0, 32'h1234, 0, 0, 3, 0);
    idle(1, 0, 0);

    // Single ALU write with hazard window on rs.
    step(1, 1, 5'd5, 0, 32'hDEADBEEF, 0, 0, 5, 0);
    idle(3, 5, 0);

    // Load then younger ALU result waiting behind it.
    step(1, 1, 5'd8, 1, 0, 0, 0, 0, 9);
    step(1, 1, 5'd9, 0, 32'd7, 0, 0, 8, 9);
    idle(1, 8, 9);
    step(1, 0, 0, 0, 0, 1, 32'h100, 8, 9);
    idle(3, 8, 9);

    // Fill the queue with loads, a fifth issue is refused, then return all.
    for (int i = 1; i <= 4; i++) step(1, 1, 5'(i), 1, 0, 0, 0, 5'(i), 0);
    step(1, 1, 5'd6, 0, 32'h66, 0, 0, 6, 4);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 0, 1, 32'(i), 1, 6);
    idle(3, 4, 6);

    // Register 0 write and a stray load return.
    step(1, 1, 5'd0, 0, 32'hABCD, 0, 0, 0, 0);
    idle(2, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h55, 0, 0);
    idle(3, 0, 0);

    // Reset mid-operation with pending entries, then a stray return.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5'd10, 1, 0, 0, 0, 10, 11);
    step(1, 1, 5'd11, 0, 32'hB, 0, 0, 10, 11);
    step(1, 1, 5'd12, 1, 0, 0, 0, 12, 11);
    step(0, 0, 0, 0, 0, 0, 0, 10, 11);
    step(1, 0, 0, 0, 0, 1, 32'h77, 10, 11);
    idle(3, 10, 12);

    // Randomized traffic with occasional resets and stray returns.
    for (int c = 0; c < 600; c++) begin
      logic rst, iv, ld, lv;
      rst = ($urandom_range(0, 79) != 0);
      iv  = ($urandom_range(0, 1) == 1);
      ld  = ($urandom_range(0, 1) == 1);
      if (outstanding_loads() > 0) lv = ($urandom_range(0, 4) < 2);
      else                         lv = ($urandom_range(0, 29) == 0);
      step(rst, iv, 5'($urandom_range(0, 7)), ld, $urandom, lv, $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    idle(8, 0, 0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
